pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential advance, branch/jump redirects (with a
// one-deep pending slot while stalled), exception/return entry with a timed flush window, and halt.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h00003000,
   parameter logic [31:0] EXC_VEC      = 32'h00004180,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JumpValid,
   input  logic [31:0] JumpTarget,
   input  logic        ExcReq,
   input  logic        EretReq,
   input  logic [31:0] Epc,
   input  logic        Halt,
   output logic [31:0] PC,
   output logic        Flush,
   output logic        Pending,
   output logic        AddrErr,
   output logic        Halted,
   output logic [1:0]  State
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_FLUSH = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

   localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ptgt_q, ptgt_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        flush_q, flush_d;
   logic        aerr_q, aerr_d;

   logic        go_s;
   logic        go_trap_s;
   logic [31:0] go_tgt_s;

   // Next-state: pick the winning event, then apply it as a single redirect.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ptgt_d    = ptgt_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      flush_d   = 1'b0;
      aerr_d    = 1'b0;
      go_s      = 1'b0;
      go_trap_s = 1'b0;
      go_tgt_s  = 32'h00000000;

      case (state_q)
         ST_RUN: begin
            if (ExcReq) begin
               go_s      = 1'b1;
               go_trap_s = 1'b1;
               go_tgt_s  = EXC_VEC;
            end else if (EretReq) begin
               go_s      = 1'b1;
               go_trap_s = 1'b1;
               go_tgt_s  = Epc;
            end else if (pend_q) begin
               // Older latched redirect wins; new branch/jump requests are dropped.
               if (!Stall) begin
                  go_s     = 1'b1;
                  go_tgt_s = ptgt_q;
                  pend_d   = 1'b0;
               end else begin
                  pc_d = pc_q;
               end
            end else if (BranchTaken || JumpValid) begin
               if (!Stall) begin
                  go_s     = 1'b1;
                  go_tgt_s = BranchTaken ? BranchTarget : JumpTarget;
               end else begin
                  pend_d = 1'b1;
                  ptgt_d = BranchTaken ? BranchTarget : JumpTarget;
               end
            end else if (Halt) begin
               state_d = ST_HALT;
            end else if (Stall) begin
               pc_d = pc_q;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         ST_FLUSH: begin
            if (ExcReq) begin
               go_s      = 1'b1;
               go_trap_s = 1'b1;
               go_tgt_s  = EXC_VEC;
            end else if (EretReq) begin
               go_s      = 1'b1;
               go_trap_s = 1'b1;
               go_tgt_s  = Epc;
            end else begin
               if (!Stall) begin
                  pc_d = pc_q + 32'd4;
               end else begin
                  pc_d = pc_q;
               end
               cnt_d = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) begin
                  state_d = ST_RUN;
                  cnt_d   = 2'd0;
               end else begin
                  flush_d = 1'b1;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (go_s) begin
         if (go_tgt_s[1:0] != 2'b00) begin
            pc_d    = EXC_VEC;
            aerr_d  = 1'b1;
            state_d = ST_FLUSH;
            cnt_d   = FC_INIT;
            pend_d  = 1'b0;
            flush_d = 1'b1;
         end else if (go_trap_s) begin
            pc_d    = go_tgt_s;
            state_d = ST_FLUSH;
            cnt_d   = FC_INIT;
            pend_d  = 1'b0;
            flush_d = 1'b1;
         end else begin
            pc_d    = go_tgt_s;
            flush_d = 1'b1;
         end
      end else begin
         go_trap_s = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         ptgt_q  <= 32'h00000000;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         flush_q <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptgt_q  <= ptgt_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         flush_q <= flush_d;
         aerr_q  <= aerr_d;
      end
   end

   assign PC      = pc_q;
   assign Flush   = flush_q;
   assign Pending = pend_q;
   assign AddrErr = aerr_q;
   assign Halted  = (state_q == ST_HALT);
   assign State   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives inputs, clocks once and
// compares all outputs against hand-computed values.
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        Reset, Stall, BranchTaken, JumpValid, ExcReq, EretReq, Halt;
   logic [31:0] BranchTarget, JumpTarget, Epc;
   logic [31:0] PC;
   logic        Flush, Pending, AddrErr, Halted;
   logic [1:0]  State;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .CLK(CLK), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .JumpValid(JumpValid), .JumpTarget(JumpTarget),
      .ExcReq(ExcReq), .EretReq(EretReq), .Epc(Epc), .Halt(Halt),
      .PC(PC), .Flush(Flush), .Pending(Pending), .AddrErr(AddrErr),
      .Halted(Halted), .State(State)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [31:0] pc, input logic [1:0] st,
                             input logic fl, input logic pd, input logic ae, input logic hl);
      chk({tag, ".pc"},      PC,              pc);
      chk({tag, ".state"},   {30'd0, State},  {30'd0, st});
      chk({tag, ".flush"},   {31'd0, Flush},  {31'd0, fl});
      chk({tag, ".pending"}, {31'd0, Pending},{31'd0, pd});
      chk({tag, ".addrerr"}, {31'd0, AddrErr},{31'd0, ae});
      chk({tag, ".halted"},  {31'd0, Halted}, {31'd0, hl});
   endtask

   initial begin
      Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; JumpValid = 1'b0;
      ExcReq = 1'b0; EretReq = 1'b0; Halt = 1'b0;
      BranchTarget = 32'h0; JumpTarget = 32'h0; Epc = 32'h0;
      tick(); tick();
      expect_all("reset", 32'h00003000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Sequential fetch after release
      Reset = 1'b0;
      tick(); expect_all("seq1", 32'h00003004, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("seq2", 32'h00003008, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("seq3", 32'h0000300C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("seq4", 32'h00003010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stalled branch latched, younger jump ignored, applied on unstall
      Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h00003100;
      tick(); expect_all("latch", 32'h00003010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      BranchTaken = 1'b0; JumpValid = 1'b1; JumpTarget = 32'h00003200;
      tick(); expect_all("pend2", 32'h00003010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      Stall = 1'b0;
      tick(); expect_all("apply", 32'h00003100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      JumpValid = 1'b0;
      tick(); expect_all("after", 32'h00003104, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Unstalled branch: one-cycle flush
      BranchTaken = 1'b1; BranchTarget = 32'h00003018;
      tick(); expect_all("br", 32'h00003018, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      BranchTaken = 1'b0;
      tick(); expect_all("br+1", 32'h0000301C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("br+2", 32'h00003020, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Exception under stall, flush window with ignored branch
      Stall = 1'b1; ExcReq = 1'b1;
      tick(); expect_all("exc", 32'h00004180, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      Stall = 1'b0; ExcReq = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h00003300;
      tick(); expect_all("exc+1", 32'h00004184, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      BranchTaken = 1'b0;
      tick(); expect_all("exc+2", 32'h00004188, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Misaligned jump target
      JumpValid = 1'b1; JumpTarget = 32'h00003102;
      tick(); expect_all("aerr", 32'h00004180, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      JumpValid = 1'b0;
      tick(); expect_all("aerr+1", 32'h00004184, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("aerr+2", 32'h00004188, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Return near the top of the address space, then wrap in RUN
      Stall = 1'b1; EretReq = 1'b1; Epc = 32'hFFFFFFF4;
      tick(); expect_all("eret", 32'hFFFFFFF4, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      Stall = 1'b0; EretReq = 1'b0;
      tick(); expect_all("eret+1", 32'hFFFFFFF8, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("eret+2", 32'hFFFFFFFC, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expect_all("wrap", 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Halt freezes everything, even exceptions
      Halt = 1'b1;
      tick(); expect_all("halt", 32'h00000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      Halt = 1'b0; ExcReq = 1'b1;
      tick(); expect_all("halt_exc", 32'h00000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      ExcReq = 1'b0; Reset = 1'b1;
      tick(); expect_all("halt_rst", 32'h00003000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset discards a pending redirect
      Reset = 1'b0; Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h00003400;
      tick(); expect_all("pend_set", 32'h00003000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0;
      tick(); expect_all("pend_rst", 32'h00003000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-flush
      Reset = 1'b0; ExcReq = 1'b1;
      tick(); expect_all("fl_set", 32'h00004180, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      ExcReq = 1'b0; Reset = 1'b1;
      tick(); expect_all("fl_rst", 32'h00003000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      tick(); expect_all("fl_rel", 32'h00003004, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
